// File: rtl/output_reorder_buff.sv
// Reorder buffer for a pipeline whose stages can be skipped. Entries are
// allocated in issue order, completed in any order by tag, and retired
// downstream strictly in issue order over a valid/ready handshake.
// Ring pointers wrap explicitly, so NUM_ENTRY need not be a power of two.
module output_reorder_buff #(
    parameter int  NUM_ENTRY  = 4,
    parameter int  WIDTH_DATA = 32,
    localparam int WIDTH_TAG  = $clog2(NUM_ENTRY),
    localparam int WIDTH_CNT  = $clog2(NUM_ENTRY + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  I_Clr,
    input  logic                  I_Issue,
    output logic                  O_Issue_Rdy,
    output logic [WIDTH_TAG-1:0]  O_Tag,
    input  logic                  I_Cmp_Valid,
    input  logic [WIDTH_TAG-1:0]  I_Cmp_Tag,
    input  logic [WIDTH_DATA-1:0] I_Cmp_Data,
    output logic                  O_Valid,
    output logic [WIDTH_DATA-1:0] O_Data,
    input  logic                  I_Rdy,
    output logic                  O_Full,
    output logic                  O_Empty,
    output logic [WIDTH_CNT-1:0]  O_Count,
    output logic                  O_Err
);

    // One extra bit so tag/pointer distances and the count share a width.
    localparam int WIDTH_OFF = WIDTH_TAG + 1;

    logic [WIDTH_TAG-1:0]  wp_r;
    logic [WIDTH_TAG-1:0]  rp_r;
    logic [WIDTH_CNT-1:0]  cnt_r;
    logic [NUM_ENTRY-1:0]  done_r;
    logic                  err_r;
    logic [WIDTH_DATA-1:0] mem_r [NUM_ENTRY];

    logic                  full_s;
    logic                  empty_s;
    logic                  alloc_s;
    logic                  valid_s;
    logic                  retire_s;
    logic [WIDTH_OFF-1:0]  tag_ext_s;
    logic [WIDTH_OFF-1:0]  rp_ext_s;
    logic [WIDTH_OFF-1:0]  off_s;
    logic                  in_range_s;
    logic                  tag_done_s;
    logic                  cmp_legal_s;
    logic                  cmp_bad_s;
    logic [NUM_ENTRY-1:0]  done_nxt_s;

    // Wrap-around increment for ring pointers of arbitrary depth.
    function automatic logic [WIDTH_TAG-1:0] ptr_next(input logic [WIDTH_TAG-1:0] p);
        if (p == WIDTH_TAG'(NUM_ENTRY - 1)) begin
            return '0;
        end else begin
            return p + WIDTH_TAG'(1);
        end
    endfunction

    assign full_s   = (cnt_r == WIDTH_CNT'(NUM_ENTRY));
    assign empty_s  = (cnt_r == WIDTH_CNT'(0));
    assign alloc_s  = I_Issue & ~full_s;
    assign valid_s  = ~empty_s & done_r[rp_r];
    assign retire_s = valid_s & I_Rdy;

    // Distance of the completion tag from the head; allocated iff below count.
    assign tag_ext_s  = {1'b0, I_Cmp_Tag};
    assign rp_ext_s   = {1'b0, rp_r};
    assign in_range_s = (tag_ext_s < WIDTH_OFF'(NUM_ENTRY));
    assign off_s      = (tag_ext_s >= rp_ext_s) ? (tag_ext_s - rp_ext_s)
                                                : (tag_ext_s + WIDTH_OFF'(NUM_ENTRY) - rp_ext_s);

    // Done flag of the completion target; out-of-range tags count as done.
    always_comb begin
        tag_done_s = 1'b1;
        if (in_range_s) begin
            tag_done_s = done_r[I_Cmp_Tag];
        end else begin
            tag_done_s = 1'b1;
        end
    end

    assign cmp_legal_s = I_Cmp_Valid & in_range_s & (off_s < WIDTH_OFF'(cnt_r)) & ~tag_done_s;
    assign cmp_bad_s   = I_Cmp_Valid & ~cmp_legal_s;

    // Next done vector: set by completion, cleared on allocate and retire.
    // These three never target the same entry in one cycle.
    always_comb begin
        done_nxt_s = done_r;
        for (int i = 0; i < NUM_ENTRY; i++) begin
            done_nxt_s[i] = (cmp_legal_s && (I_Cmp_Tag == WIDTH_TAG'(i))) ? 1'b1 :
                            ((alloc_s && (wp_r == WIDTH_TAG'(i))) ||
                             (retire_s && (rp_r == WIDTH_TAG'(i)))) ? 1'b0 : done_r[i];
        end
    end

    // Control state: pointers, occupancy, done flags and sticky error.
    always_ff @(posedge clock) begin
        if (reset || I_Clr) begin
            wp_r   <= '0;
            rp_r   <= '0;
            cnt_r  <= '0;
            done_r <= '0;
            err_r  <= 1'b0;
        end else begin
            done_r <= done_nxt_s;
            err_r  <= err_r | cmp_bad_s;
            if (alloc_s) begin
                wp_r <= ptr_next(wp_r);
            end
            if (retire_s) begin
                rp_r <= ptr_next(rp_r);
            end
            case ({alloc_s, retire_s})
                2'b10:   cnt_r <= cnt_r + WIDTH_CNT'(1);
                2'b01:   cnt_r <= cnt_r - WIDTH_CNT'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    // Payload storage: written only by legal completions, never reset.
    always_ff @(posedge clock) begin
        if (cmp_legal_s && !reset && !I_Clr) begin
            mem_r[I_Cmp_Tag] <= I_Cmp_Data;
        end
    end

    assign O_Issue_Rdy = ~full_s;
    assign O_Tag       = wp_r;
    assign O_Valid     = valid_s;
    assign O_Data      = mem_r[rp_r];
    assign O_Full      = full_s;
    assign O_Empty     = empty_s;
    assign O_Count     = cnt_r;
    assign O_Err       = err_r;

endmodule
